// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch_pkg                                           |
// | Purpose  : Shared sizing constants and helpers for the fetch queue.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package instruction_fetch_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int WORD_BYTES         = DEFAULT_WORD_WIDTH / 8;
    localparam int WORD_SHIFT         = $clog2(WORD_BYTES);
    localparam int MAX_INSN_BYTES     = 1 + WORD_BYTES;

    function automatic int word_bytes(input int word_width);
        return word_width / 8;
    endfunction

    function automatic int word_shift(input int word_width);
        return $clog2(word_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_byte_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_byte_queue                                                |
// | Purpose  : Circular byte buffer, up to one word written and one            |
// |            instruction retired per cycle, with a read window at the head.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_byte_queue
    import instruction_fetch_pkg::*;
#(
    parameter int WR_BYTES = WORD_BYTES,
    parameter int RD_BYTES = MAX_INSN_BYTES,
    parameter int DEPTH    = 16,
    parameter int SKIP_W   = 2,
    parameter int LEN_W    = 3,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [SKIP_W-1:0]     wr_skip,
    input  logic [WR_BYTES*8-1:0] wr_data,
    input  logic [LEN_W-1:0]      rd_len,
    output logic [RD_BYTES*8-1:0] rd_window,
    output logic [CNT_W-1:0]      count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [7:0]          r_mem [DEPTH];
    logic [CNT_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_wr_num;
    logic [CNT_W-1:0]    w_rd_num;
    logic [WR_BYTES*8-1:0] w_shifted;
    logic [c_aw-1:0]     w_wr_idx [WR_BYTES];

    // Leading skipped bytes are shifted out so the survivors pack from the tail.
    always_comb begin
        w_wr_num  = wr_en ? (CNT_W'(WR_BYTES) - CNT_W'(wr_skip)) : '0;
        w_rd_num  = CNT_W'(rd_len);
        w_shifted = wr_data >> {wr_skip, 3'b000};
    end

    for (genvar i = 0; i < WR_BYTES; i++) begin : g_wr_idx
        assign w_wr_idx[i] = r_wr_ptr[c_aw-1:0] + c_aw'(i);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            for (int i = 0; i < WR_BYTES; i++) begin
                if (CNT_W'(i) < w_wr_num) begin
                    r_mem[w_wr_idx[i]] <= w_shifted[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_wr_num;
            r_rd_ptr <= r_rd_ptr + w_rd_num;
            r_count  <= r_count + w_wr_num - w_rd_num;
        end
    end

    // Bytes beyond the current fill level read as zero.
    for (genvar k = 0; k < RD_BYTES; k++) begin : g_window
        assign rd_window[k*8 +: 8] = (CNT_W'(k) < r_count)
                                   ? r_mem[r_rd_ptr[c_aw-1:0] + c_aw'(k)] : 8'h00;
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instruction_fetch                                               |
// | Purpose  : Word fetcher feeding a byte queue; retires one instruction per  |
// |            accept using the externally computed next pc. Optional stall    |
// |            counter enabled with FETCH_STALL_COUNT_EN.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int WORD_WIDTH         = 32,
    parameter int PROGRAM_ADDR_WIDTH = 16,
    parameter int QUEUE_BYTES        = 16
) (
    input  logic                                                    clk,
    input  logic                                                    reset,
    output logic                                                    mem_re,
    output logic [PROGRAM_ADDR_WIDTH-word_shift(WORD_WIDTH)-1:0]    mem_addr,
    input  logic [WORD_WIDTH-1:0]                                   mem_data,
    output logic [7:0]                                              instruction,
    output logic [WORD_WIDTH-1:0]                                   immediate,
    output logic [PROGRAM_ADDR_WIDTH-1:0]                           pc,
    input  logic [PROGRAM_ADDR_WIDTH-1:0]                           pc_advance,
    output logic                                                    insn_valid,
    input  logic                                                    insn_ready,
`ifdef FETCH_STALL_COUNT_EN
    output logic [31:0]                                             stall_count,
`endif
    input  logic                                                    redirect,
    input  logic [PROGRAM_ADDR_WIDTH-1:0]                           redirect_pc
);

    localparam int c_word_bytes = word_bytes(WORD_WIDTH);
    localparam int c_word_shift = word_shift(WORD_WIDTH);
    localparam int c_max_insn   = 1 + c_word_bytes;
    localparam int c_fa_w       = PROGRAM_ADDR_WIDTH - c_word_shift;
    localparam int c_skip_w     = (c_word_shift > 0) ? c_word_shift : 1;
    localparam int c_len_w      = $clog2(c_max_insn + 1);
    localparam int c_cnt_w      = $clog2(QUEUE_BYTES) + 1;
    localparam int c_used_w     = c_cnt_w + 1;

    logic [PROGRAM_ADDR_WIDTH-1:0] r_pc;
    logic [c_fa_w-1:0]             r_fetch_ptr;
    logic                          r_in_flight;
    logic [c_skip_w-1:0]           r_skip;
    logic                          r_run;

    logic [c_cnt_w-1:0]            w_count;
    logic [c_max_insn*8-1:0]       w_window;
    logic [PROGRAM_ADDR_WIDTH-1:0] w_len;
    logic [c_len_w-1:0]            w_rd_len;
    logic [c_used_w-1:0]           w_used;
    logic [c_skip_w-1:0]           w_redir_skip;
    logic                          w_accept;
    logic                          w_wr_en;

    if (c_word_shift > 0) begin : g_skip
        assign w_redir_skip = redirect_pc[c_skip_w-1:0];
    end else begin : g_no_skip
        assign w_redir_skip = '0;
    end

    // Credit counts bytes already queued plus a full word for any read in flight.
    always_comb begin
        w_len      = pc_advance - r_pc;
        insn_valid = !redirect && (32'(w_count) >= 32'(w_len));
        w_accept   = insn_valid && insn_ready;
        w_rd_len   = w_accept ? w_len[c_len_w-1:0] : '0;
        w_used     = c_used_w'(w_count) + (r_in_flight ? c_used_w'(c_word_bytes) : '0);
        mem_re     = r_run && !redirect
                   && (w_used <= c_used_w'(QUEUE_BYTES - c_word_bytes));
        w_wr_en    = r_in_flight && !redirect;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_fetch_ptr <= '0;
            r_in_flight <= 1'b0;
            r_skip      <= '0;
            r_run       <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_in_flight <= mem_re;
            if (redirect) begin
                r_pc        <= redirect_pc;
                r_fetch_ptr <= redirect_pc[PROGRAM_ADDR_WIDTH-1:c_word_shift];
                r_skip      <= w_redir_skip;
            end else begin
                if (mem_re) begin
                    r_fetch_ptr <= r_fetch_ptr + 1'b1;
                end
                if (w_wr_en) begin
                    r_skip <= '0;
                end
                if (w_accept) begin
                    r_pc <= pc_advance;
                end
            end
        end
    end

    fetch_byte_queue #(
        .WR_BYTES (c_word_bytes),
        .RD_BYTES (c_max_insn),
        .DEPTH    (QUEUE_BYTES),
        .SKIP_W   (c_skip_w),
        .LEN_W    (c_len_w)
    ) u_queue (
        .clk       (clk),
        .rst       (reset),
        .clear     (redirect),
        .wr_en     (w_wr_en),
        .wr_skip   (r_skip),
        .wr_data   (mem_data),
        .rd_len    (w_rd_len),
        .rd_window (w_window),
        .count     (w_count)
    );

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (insn_ready && !insn_valid && !redirect && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign mem_addr    = r_fetch_ptr;
    assign pc          = r_pc;
    assign instruction = w_window[7:0];
    assign immediate   = w_window[8 +: WORD_WIDTH];

endmodule
`default_nettype wire
